// File: rtl/dmem_sram_like_bridge_pkg.sv
// -----------------------------------------------------------------------------
// dmem_sram_like_bridge_pkg
//   Shared definitions for the data-memory sram-like bridge and its address
//   mapper:
//     brg_state_t  - bridge FSM state encoding (2 bits)
//     SIZE_*       - bus transfer size codes
//     brg_dbg_t    - debug view of the bridge's internal state
//     is_kseg01()  - true for kseg0/kseg1 virtual addresses
// -----------------------------------------------------------------------------
package dmem_sram_like_bridge_pkg;

    typedef enum logic [1:0] {
        BRG_IDLE = 2'd0,
        BRG_ADDR = 2'd1,
        BRG_DATA = 2'd2,
        BRG_DONE = 2'd3
    } brg_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Debug view: current state, pending-flush flag, and the direction and
    // byte lanes of the access currently held by the bridge.
    typedef struct packed {
        brg_state_t state;
        logic       flush_pend;
        logic       we;
        logic [3:0] sel;
    } brg_dbg_t;

    // kseg0 (0x8000_0000..0x9FFF_FFFF) and kseg1 (0xA000_0000..0xBFFF_FFFF)
    function automatic logic is_kseg01(input logic [31:0] addr);
        return addr[31:30] == 2'b10;
    endfunction

endpackage

// File: rtl/dmem_addr_map.sv
// -----------------------------------------------------------------------------
// dmem_addr_map
//   Combinational virtual-to-physical address mapper. With KSEG_MAP != 0,
//   kseg0/kseg1 addresses have bits [31:29] cleared; every other segment
//   passes through unchanged. With KSEG_MAP == 0 the address is untouched.
//   Ports:
//     vaddr  in  32  virtual address
//     paddr  out 32  physical address
// -----------------------------------------------------------------------------
module dmem_addr_map
    import dmem_sram_like_bridge_pkg::*;
#(
    parameter int KSEG_MAP = 1
) (
    input  logic [31:0] vaddr,
    output logic [31:0] paddr
);

    always_comb begin
        paddr = vaddr;
        if ((KSEG_MAP != 0) && is_kseg01(vaddr)) begin
            paddr = {3'b000, vaddr[28:0]};
        end
    end

endmodule

// File: rtl/dmem_sram_like_bridge.sv
// -----------------------------------------------------------------------------
// dmem_sram_like_bridge
//   Turns the core's single-cycle data-memory access into a two-phase
//   sram-like bus transaction and stalls the pipeline until it completes.
//   Ports:
//     clk, rst                 clock, asynchronous active-low reset
//     cpu_mem_en/we/sel/size   core access request (held stable while stalled)
//     cpu_addr, cpu_wdata      virtual address, lane-aligned store data
//     cpu_longest_stall        OR of all pipeline stall sources
//     cpu_flush                MEM-stage exception flush
//     cpu_rdata                load data (stable until the next load completes)
//     stallreq_from_mem        stall request to the hazard unit
//     data_req/wr/size/addr/wdata, data_addr_ok/data_ok/rdata  sram-like bus
//     dbg                      internal state view
//
//   Bus handshake: the address phase completes in the cycle where data_req
//   and data_addr_ok are both high; once completed, data_req is not raised
//   again for this access. The data phase completes in the first later (or
//   the same) cycle where data_data_ok is high; data_rdata is valid only then.
//   An address phase not yet accepted may be withdrawn by a flush; an accepted
//   one is always drained.
// -----------------------------------------------------------------------------
module dmem_sram_like_bridge
    import dmem_sram_like_bridge_pkg::*;
#(
    parameter int KSEG_MAP = 1,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_mem_en,
    input  logic              cpu_mem_we,
    input  logic [3:0]        cpu_sel,
    input  logic [1:0]        cpu_size,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic              cpu_longest_stall,
    input  logic              cpu_flush,
    output logic [31:0]       cpu_rdata,
    output logic              stallreq_from_mem,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output brg_dbg_t          dbg
);

    brg_state_t  state_q;
    logic        flush_pend_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] rdata_q;
    logic [31:0] paddr;

    dmem_addr_map #(.KSEG_MAP(KSEG_MAP)) u_addr_map (
        .vaddr (cpu_addr),
        .paddr (paddr)
    );

    assign data_wr    = cpu_mem_we;
    assign data_size  = cpu_size;
    assign data_wdata = cpu_wdata;
    assign data_addr  = paddr[ADDR_W-1:0];
    assign cpu_rdata  = rdata_q;

    // Request and stall are gated by reset so the bus sees nothing while the
    // bridge is held in reset, even if the core still presents an access.
    assign data_req = rst & ((state_q == BRG_ADDR) |
                             ((state_q == BRG_IDLE) & cpu_mem_en & ~cpu_flush));

    // In DATA the stall holds even if the core dropped mem_en after a flush:
    // the outstanding response must be drained before anything new issues.
    assign stallreq_from_mem = rst & ((cpu_mem_en & (state_q != BRG_DONE)) |
                                      (state_q == BRG_DATA));

    always_comb begin
        dbg            = '0;
        dbg.state      = state_q;
        dbg.flush_pend = flush_pend_q;
        dbg.we         = we_q;
        dbg.sel        = sel_q;
    end

    // Direction is latched at issue because a flush lets the core change its
    // cpu_* inputs while the access is still being drained. A flushed access
    // never updates the load data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= BRG_IDLE;
            flush_pend_q <= 1'b0;
            we_q         <= 1'b0;
            sel_q        <= 4'd0;
            rdata_q      <= 32'd0;
        end else begin
            case (state_q)
                BRG_IDLE: begin
                    if (cpu_mem_en && !cpu_flush) begin
                        we_q         <= cpu_mem_we;
                        sel_q        <= cpu_sel;
                        flush_pend_q <= 1'b0;
                        if (data_addr_ok && data_data_ok) begin
                            state_q <= BRG_DONE;
                            if (!cpu_mem_we) rdata_q <= data_rdata;
                        end else if (data_addr_ok) begin
                            state_q <= BRG_DATA;
                        end else begin
                            state_q <= BRG_ADDR;
                        end
                    end
                end
                BRG_ADDR: begin
                    if (data_addr_ok) begin
                        // Accepted in the same cycle as a flush: must drain.
                        flush_pend_q <= cpu_flush;
                        if (data_data_ok) begin
                            state_q <= BRG_DONE;
                            if (!we_q && !cpu_flush) rdata_q <= data_rdata;
                        end else begin
                            state_q <= BRG_DATA;
                        end
                    end else if (cpu_flush) begin
                        state_q <= BRG_IDLE;
                    end
                end
                BRG_DATA: begin
                    if (cpu_flush) flush_pend_q <= 1'b1;
                    if (data_data_ok) begin
                        state_q <= BRG_DONE;
                        if (!we_q && !flush_pend_q && !cpu_flush) begin
                            rdata_q <= data_rdata;
                        end
                    end
                end
                BRG_DONE: begin
                    if (flush_pend_q || !cpu_longest_stall) begin
                        state_q      <= BRG_IDLE;
                        flush_pend_q <= 1'b0;
                    end
                end
                default: state_q <= BRG_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_sram_like_bridge.sv
// -----------------------------------------------------------------------------
// tb_dmem_sram_like_bridge
//   Self-checking bench: reset values, an address/pass-through vector table,
//   hand-written multi-cycle sequences (timing, stall hold, flush, reset) and
//   randomized transactions checked against a timing/data reference model.
// -----------------------------------------------------------------------------
module tb_dmem_sram_like_bridge;
    import dmem_sram_like_bridge_pkg::*;

    logic        clk;
    logic        rst;
    logic        cpu_mem_en;
    logic        cpu_mem_we;
    logic [3:0]  cpu_sel;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_longest_stall;
    logic        cpu_flush;
    logic [31:0] cpu_rdata;
    logic        stallreq_from_mem;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    brg_dbg_t    dbg;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] model_rdata;
    logic [31:0] exp_q[$];

    dmem_sram_like_bridge #(.KSEG_MAP(1), .ADDR_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .cpu_mem_en        (cpu_mem_en),
        .cpu_mem_we        (cpu_mem_we),
        .cpu_sel           (cpu_sel),
        .cpu_size          (cpu_size),
        .cpu_addr          (cpu_addr),
        .cpu_wdata         (cpu_wdata),
        .cpu_longest_stall (cpu_longest_stall),
        .cpu_flush         (cpu_flush),
        .cpu_rdata         (cpu_rdata),
        .stallreq_from_mem (stallreq_from_mem),
        .data_req          (data_req),
        .data_wr           (data_wr),
        .data_size         (data_size),
        .data_addr         (data_addr),
        .data_wdata        (data_wdata),
        .data_addr_ok      (data_addr_ok),
        .data_data_ok      (data_data_ok),
        .data_rdata        (data_rdata),
        .dbg               (dbg)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // Segment rule from the memory map: kseg0/kseg1 fold onto the low 512 MB.
    function automatic logic [31:0] map_addr(input logic [31:0] va);
        if (va >= 32'h8000_0000 && va < 32'hC000_0000) return va % 32'h2000_0000;
        return va;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One access. a = cycles before addr_ok, d = cycles from address accept to
    // data_ok (0 = same cycle), extra = cycles other stages keep stalling after
    // the access is done. Expected stall/request counts come from the model.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic [3:0] sel, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int a, input int d,
                           input int extra, input string tag);
        int exp_stall;
        int n;
        int req_cnt;
        int stall_cnt;
        int late_req;
        int done_bad;
        logic [31:0] exp_rdata;
        exp_stall = (d == 0) ? a + 1 : a + d + 1;
        n         = exp_stall + 1 + extra;
        exp_rdata = we ? model_rdata : rdata;
        exp_q.push_back(exp_rdata);
        req_cnt = 0; stall_cnt = 0; late_req = 0; done_bad = 0;
        for (int c = 0; c < n; c++) begin
            cpu_mem_en        = 1'b1;
            cpu_mem_we        = we;
            cpu_addr          = addr;
            cpu_size          = size;
            cpu_sel           = sel;
            cpu_wdata         = wdata;
            cpu_flush         = 1'b0;
            data_addr_ok      = (c == a);
            data_data_ok      = (c == a + d);
            data_rdata        = (c == a + d) ? rdata : $urandom;
            cpu_longest_stall = (c < exp_stall + extra);
            @(negedge clk);
            if (data_req) req_cnt++;
            if (data_req && c > a) late_req++;
            if (stallreq_from_mem) stall_cnt++;
            if (c == 0) begin
                check({tag, " addr"}, data_addr, map_addr(addr));
                check({tag, " wr/size"}, {29'd0, data_wr, data_size}, {29'd0, we, size});
                check({tag, " wdata"}, data_wdata, wdata);
            end
            if (c >= exp_stall && cpu_rdata !== exp_rdata) done_bad++;
            next_cycle();
        end
        cpu_mem_en   = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        cpu_longest_stall = 1'b0;
        @(negedge clk);
        check({tag, " req_cycles"}, req_cnt, a + 1);
        check({tag, " reissue"}, late_req, 0);
        check({tag, " stall_cycles"}, stall_cnt, exp_stall);
        check({tag, " rdata_in_done"}, done_bad, 0);
        check({tag, " back_to_idle"}, {30'd0, dbg.state}, {30'd0, BRG_IDLE});
        check({tag, " rdata_after"}, cpu_rdata, exp_q.pop_front());
        model_rdata = exp_rdata;
        next_cycle();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'h8000_1004, 1'b1, SIZE_WORD, 32'h1234_5678, 32'h0000_1004};
        vecs[1] = '{32'hA000_0010, 1'b0, SIZE_BYTE, 32'h0000_00AA, 32'h0000_0010};
        vecs[2] = '{32'hBFC0_0000, 1'b0, SIZE_WORD, 32'hFFFF_FFFF, 32'h1FC0_0000};
        vecs[3] = '{32'h9FFF_FFFF, 1'b1, SIZE_HALF, 32'h5A5A_0000, 32'h1FFF_FFFF};
        vecs[4] = '{32'h0040_0000, 1'b1, SIZE_HALF, 32'h0000_BEEF, 32'h0040_0000};
        vecs[5] = '{32'h7FFF_FFFC, 1'b0, SIZE_WORD, 32'h0000_0000, 32'h7FFF_FFFC};
        vecs[6] = '{32'hC000_0000, 1'b1, SIZE_BYTE, 32'h0000_0011, 32'hC000_0000};
        vecs[7] = '{32'hFFFF_FFFC, 1'b0, SIZE_WORD, 32'hCAFE_F00D, 32'hFFFF_FFFC};
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b0;
        cpu_mem_en = 1'b0; cpu_mem_we = 1'b0; cpu_sel = 4'h0; cpu_size = 2'd0;
        cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_longest_stall = 1'b0; cpu_flush = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
        model_rdata = 32'd0;

        #3;
        check("reset rdata", cpu_rdata, 32'd0);
        check("reset state", {30'd0, dbg.state}, {30'd0, BRG_IDLE});
        check("reset req", {31'd0, data_req}, 32'd0);
        check("reset stall", {31'd0, stallreq_from_mem}, 32'd0);
        #9 rst = 1'b1;
        next_cycle();

        // Table: address mapping and combinational pass-through while idle.
        foreach (vecs[i]) begin
            cpu_addr = vecs[i].addr; cpu_mem_we = vecs[i].we;
            cpu_size = vecs[i].size; cpu_wdata = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d addr", i), data_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d wr/size", i), {29'd0, data_wr, data_size},
                  {29'd0, vecs[i].we, vecs[i].size});
            check($sformatf("vec%0d idle_req", i), {31'd0, data_req}, 32'd0);
        end
        next_cycle();

        // Load: immediate addr_ok, data_ok four DATA cycles later -> 5 stall cycles.
        run_txn(1'b0, 32'h8000_0200, SIZE_WORD, 4'hF, 32'd0, 32'hDEAD_BEEF, 0, 4, 0, "load_slow");
        // Store with addr_ok delayed 2 cycles -> request held 3 cycles.
        run_txn(1'b1, 32'h8000_1004, SIZE_WORD, 4'hF, 32'h1234_5678, 32'h0BAD_0BAD, 2, 1, 0, "store_dly");
        // Both handshakes in the request cycle -> 1 stall cycle.
        run_txn(1'b0, 32'h0000_0040, SIZE_HALF, 4'h3, 32'd0, 32'h0000_CAFE, 0, 0, 0, "load_fast");
        // Another stage stalls 4 extra cycles while DONE.
        run_txn(1'b0, 32'hA000_0080, SIZE_BYTE, 4'h1, 32'd0, 32'h0000_0077, 1, 2, 4, "load_hold");

        // Flush while waiting for addr_ok: request withdrawn.
        cpu_mem_en = 1'b1; cpu_mem_we = 1'b0; cpu_addr = 32'h0000_1000; cpu_size = SIZE_WORD;
        cpu_longest_stall = 1'b1;
        @(negedge clk);
        check("fa req0", {31'd0, data_req}, 32'd1);
        next_cycle();
        cpu_flush = 1'b1;
        @(negedge clk);
        check("fa req_in_addr", {31'd0, data_req}, 32'd1);
        next_cycle();
        cpu_flush = 1'b0; cpu_mem_en = 1'b0; cpu_longest_stall = 1'b0;
        @(negedge clk);
        check("fa req_dropped", {31'd0, data_req}, 32'd0);
        check("fa state", {30'd0, dbg.state}, {30'd0, BRG_IDLE});
        check("fa stall", {31'd0, stallreq_from_mem}, 32'd0);
        next_cycle();

        // Flush of a store during DATA: drained, then IDLE, load data untouched.
        cpu_mem_en = 1'b1; cpu_mem_we = 1'b1; cpu_addr = 32'h8000_2000;
        cpu_wdata = 32'h5555_AAAA; data_addr_ok = 1'b1; cpu_longest_stall = 1'b1;
        @(negedge clk);
        check("fd req", {31'd0, data_req}, 32'd1);
        next_cycle();
        data_addr_ok = 1'b0; cpu_flush = 1'b1;
        @(negedge clk);
        check("fd no_req_in_data", {31'd0, data_req}, 32'd0);
        next_cycle();
        cpu_flush = 1'b0; cpu_mem_en = 1'b0; cpu_mem_we = 1'b0;
        @(negedge clk);
        check("fd drain_stall", {31'd0, stallreq_from_mem}, 32'd1);
        check("fd drain_req", {31'd0, data_req}, 32'd0);
        next_cycle();
        data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        next_cycle();
        data_data_ok = 1'b0;
        @(negedge clk);
        check("fd done", {30'd0, dbg.state}, {30'd0, BRG_DONE});
        next_cycle();
        @(negedge clk);
        check("fd idle_despite_stall", {30'd0, dbg.state}, {30'd0, BRG_IDLE});
        check("fd rdata_kept", cpu_rdata, model_rdata);
        cpu_longest_stall = 1'b0;
        next_cycle();

        // Random accesses against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra;
            ra = $urandom;
            run_txn(1'($urandom_range(0, 1)), ra, 2'($urandom_range(0, 2)),
                    4'($urandom_range(0, 15)), $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
                    $sformatf("rnd%0d", i));
        end

        // Asynchronous reset while a load sits in DATA.
        cpu_mem_en = 1'b1; cpu_mem_we = 1'b0; cpu_addr = 32'h0000_3000;
        data_addr_ok = 1'b1; cpu_longest_stall = 1'b1;
        next_cycle();
        data_addr_ok = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst state", {30'd0, dbg.state}, {30'd0, BRG_IDLE});
        check("rst req", {31'd0, data_req}, 32'd0);
        check("rst stall", {31'd0, stallreq_from_mem}, 32'd0);
        check("rst rdata", cpu_rdata, 32'd0);
        cpu_mem_en = 1'b0; cpu_longest_stall = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst after_release", {30'd0, dbg.state}, {30'd0, BRG_IDLE});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
